// File: rtl/parity_pkg.sv
// Shared types and framing constants for the even-parity receive path.
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/parity_frame_deserializer.sv
// Strobe-sampled serial frame receiver (start, DATA_W bits LSB-first, parity, stop)
// presenting {data_out, parity_out} on a valid/ready output register.
module parity_frame_deserializer
  import parity_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              framing_err,
  output logic              overrun
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_accept;

  // New bits enter at the MSB so the first received bit ends up at bit 0.
  always_comb begin
    w_shift_nxt             = r_shift >> 1;
    w_shift_nxt[DATA_W-1]   = serial_in;
  end

  assign w_accept = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      data_out    <= '0;
      parity_out  <= 1'b0;
      out_valid   <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      if (w_accept) out_valid <= 1'b0;

      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (serial_in == START_BIT) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_shift <= w_shift_nxt;
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
              r_cnt   <= '0;
              r_state <= PARITY;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            r_par   <= serial_in;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (serial_in == STOP_BIT) begin
              // A slot frees up this cycle if it is empty or being accepted now.
              if (!out_valid || out_ready) begin
                data_out   <= r_shift;
                parity_out <= r_par;
                out_valid  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_parity_frame_deserializer.sv
// Scoreboard bench for parity_frame_deserializer (DATA_W=4).
module tb_parity_frame_deserializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       serial_in = 1'b1;
  logic [3:0] data_out;
  logic       parity_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       framing_err;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int n_fe   = 0;
  int n_ov   = 0;
  int n_pop  = 0;
  logic [4:0] sb_q[$];

  parity_frame_deserializer #(.DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .serial_in(serial_in),
    .data_out(data_out), .parity_out(parity_out), .out_valid(out_valid),
    .out_ready(out_ready), .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: pre-edge values at the accepting edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (framing_err) n_fe++;
      if (overrun) n_ov++;
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb_q.size() == 0) chk("sb_unexpected", {27'd0, data_out, parity_out}, 32'hFFFF_FFFF);
        else chk("sb_frame", {27'd0, data_out, parity_out}, {27'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic strobe(input logic b);
    bit_en = 1'b1;
    serial_in = b;
    @(negedge clk);
    bit_en = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input logic rdy_stop);
    logic prev;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(d[i]);
    strobe(p);
    prev = out_ready;
    if (rdy_stop) out_ready = 1'b1;
    strobe(s);
    out_ready = prev;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {28'd0, data_out}, 32'd0);
    chk("rst_fe", {31'd0, framing_err}, 32'd0);
    chk("rst_ov", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame: start, 1010 LSB-first, parity 0, stop
    strobe(0); strobe(1); strobe(0); strobe(1); strobe(0); strobe(0); strobe(1);
    chk("good_valid", {31'd0, out_valid}, 32'd1);
    chk("good_data", {28'd0, data_out}, 32'h5);
    chk("good_par", {31'd0, parity_out}, 32'd0);
    sb_q.push_back({4'h5, 1'b0});
    accept();
    chk("good_clear", {31'd0, out_valid}, 32'd0);
    chk("good_keep", {28'd0, data_out}, 32'h5);

    // Framing error
    send_frame(4'h3, 1'b0, 1'b0, 1'b0);
    chk("fe_pulse", {31'd0, framing_err}, 32'd1);
    chk("fe_novalid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("fe_1clk", {31'd0, framing_err}, 32'd0);

    // Overrun: held 4'h1 survives a second frame
    send_frame(4'h1, 1'b1, 1'b1, 1'b0);
    sb_q.push_back({4'h1, 1'b1});
    chk("ov_hold_par", {31'd0, parity_out}, 32'd1);
    send_frame(4'hF, 1'b0, 1'b1, 1'b0);
    chk("ov_pulse", {31'd0, overrun}, 32'd1);
    chk("ov_keep", {28'd0, data_out}, 32'h1);
    chk("ov_fe0", {31'd0, framing_err}, 32'd0);
    @(negedge clk);
    chk("ov_1clk", {31'd0, overrun}, 32'd0);
    accept();
    chk("ov_drain", {31'd0, out_valid}, 32'd0);

    // Same-cycle accept and load
    send_frame(4'h2, 1'b0, 1'b1, 1'b0);
    sb_q.push_back({4'h2, 1'b0});
    send_frame(4'h7, 1'b1, 1'b1, 1'b1);
    sb_q.push_back({4'h7, 1'b1});
    chk("al_valid", {31'd0, out_valid}, 32'd1);
    chk("al_data", {28'd0, data_out}, 32'h7);
    chk("al_noov", {31'd0, overrun}, 32'd0);
    accept();

    // Strobe gating: line toggles between strobes mid-frame must be ignored
    strobe(1'b0);
    for (int i = 0; i < 6; i++) begin serial_in = i[0]; @(negedge clk); end
    strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b0);
    for (int i = 0; i < 4; i++) begin serial_in = ~i[0]; @(negedge clk); end
    strobe(1'b1); strobe(1'b1);
    sb_q.push_back({4'h6, 1'b1});
    chk("gate_data", {28'd0, data_out}, 32'h6);
    accept();
    // Idle-high strobes never start a frame
    for (int i = 0; i < 12; i++) strobe(1'b1);
    chk("idle_novalid", {31'd0, out_valid}, 32'd0);

    // Reset mid-frame with a held frame present
    send_frame(4'h9, 1'b0, 1'b1, 1'b0);
    strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_data", {28'd0, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(4'hA, 1'b0, 1'b1, 1'b0);
    sb_q.push_back({4'hA, 1'b0});
    chk("mrst_frame", {28'd0, data_out}, 32'hA);
    accept();

    @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("n_pop", n_pop, 32'd6);
    chk("n_fe", n_fe, 32'd1);
    chk("n_ov", n_ov, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
